// File: rtl/tcm_sram.sv
// tcm_sram: dual-requester byte-maskable single-port TCM bank with round-robin arbitration
module tcm_sram #(
  parameter int AW    = 14,
  parameter int DW    = 32,
  parameter int MW    = DW / 8,
  parameter int DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_cmd_valid,
  output logic          a_cmd_ready,
  input  logic          a_cmd_read,
  input  logic [AW-1:0] a_cmd_addr,
  input  logic [DW-1:0] a_cmd_wdata,
  input  logic [MW-1:0] a_cmd_wmask,
  output logic          a_rsp_valid,
  input  logic          a_rsp_ready,
  output logic [DW-1:0] a_rsp_rdata,
  output logic          a_rsp_err,
  input  logic          b_cmd_valid,
  output logic          b_cmd_ready,
  input  logic          b_cmd_read,
  input  logic [AW-1:0] b_cmd_addr,
  input  logic [DW-1:0] b_cmd_wdata,
  input  logic [MW-1:0] b_cmd_wmask,
  output logic          b_rsp_valid,
  input  logic          b_rsp_ready,
  output logic [DW-1:0] b_rsp_rdata,
  output logic          b_rsp_err
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DW-1:0] r_mem [DEPTH];
  logic          r_ptr;
  logic          r_a_valid, r_b_valid, r_a_err, r_b_err;
  logic [DW-1:0] r_a_rdata, r_b_rdata;
  logic          w_ea, w_eb, w_ga, w_gb, w_go, w_read, w_in, w_we, w_rd_ok;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata, w_rdata;
  logic [MW-1:0] w_mask;
  logic [IW-1:0] w_idx;
  // Eligibility, round-robin grant and the muxed command of the granted channel
  always_comb begin
    w_ea    = a_cmd_valid & (~r_a_valid | a_rsp_ready);
    w_eb    = b_cmd_valid & (~r_b_valid | b_rsp_ready);
    w_ga    = w_ea & (~w_eb | ~r_ptr);
    w_gb    = w_eb & (~w_ea | r_ptr);
    w_go    = w_ga | w_gb;
    w_read  = w_ga ? a_cmd_read  : b_cmd_read;
    w_addr  = w_ga ? a_cmd_addr  : b_cmd_addr;
    w_wdata = w_ga ? a_cmd_wdata : b_cmd_wdata;
    w_mask  = w_ga ? a_cmd_wmask : b_cmd_wmask;
    w_in    = 32'(w_addr) < 32'(DEPTH);
    w_idx   = w_addr[IW-1:0];
    w_we    = w_go & ~w_read & w_in;
    w_rd_ok = w_read & w_in;
    w_rdata = r_mem[w_idx];
  end
  assign a_cmd_ready = w_ga;
  assign b_cmd_ready = w_gb;
  assign a_rsp_valid = r_a_valid;
  assign a_rsp_rdata = r_a_rdata;
  assign a_rsp_err   = r_a_err;
  assign b_rsp_valid = r_b_valid;
  assign b_rsp_rdata = r_b_rdata;
  assign b_rsp_err   = r_b_err;
  // Byte-masked array write; contents are never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < MW; i++)
      if (w_we && w_mask[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  end
  // Priority pointer moves to the channel that lost this grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= 1'b0;
    else if (w_go) r_ptr <= w_ga;
  end
  // Channel A response register, held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_rdata <= '0;
      r_a_err   <= 1'b0;
    end else if (w_ga) begin
      r_a_valid <= 1'b1;
      r_a_rdata <= w_rd_ok ? w_rdata : '0;
      r_a_err   <= ~w_in;
    end else if (a_rsp_ready) begin
      r_a_valid <= 1'b0;
    end
  end
  // Channel B response register, held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid <= 1'b0;
      r_b_rdata <= '0;
      r_b_err   <= 1'b0;
    end else if (w_gb) begin
      r_b_valid <= 1'b1;
      r_b_rdata <= w_rd_ok ? w_rdata : '0;
      r_b_err   <= ~w_in;
    end else if (b_rsp_ready) begin
      r_b_valid <= 1'b0;
    end
  end
endmodule
